// File: rtl/change_dispense_ctrl.sv
// Shared coin-ejector controller for two vending channels: round-robin arbitration,
// inventory feasibility check, and one-coin-at-a-time payout (5-leu first, then 1-leu).
module change_dispense_ctrl #(
   parameter int AMT_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic [AMT_W-1:0] amt_a,
   input  logic             req_b,
   input  logic [AMT_W-1:0] amt_b,
   output logic             ack_a,
   output logic             short_a,
   output logic             ack_b,
   output logic             short_b,
   output logic             ej1,
   output logic             ej5,
   input  logic             ej_done,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_c1,
   input  logic [CNT_W-1:0] load_c5,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt5,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_EJECT, S_GAP, S_DONE, S_REJECT
   } state_t;

   localparam int W = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 3;

   state_t           state, state_nxt;
   logic             gnt, gnt_nxt;      // granted channel: 0=A, 1=B
   logic             rr, rr_nxt;        // round-robin pointer: 0=A, 1=B
   logic [AMT_W-1:0] amt_q, amt_nxt;
   logic [AMT_W-1:0] n5, n5_nxt, n1, n1_nxt;
   logic [CNT_W-1:0] c1_q, c5_q, c1_nxt, c5_nxt;
   logic             dec1, dec5;
   logic [W-1:0]     q5, n5_calc, n1_calc;
   logic             fits;
   logic             ack_a_d, short_a_d, ack_b_d, short_b_d, ej1_d, ej5_d, busy_d;

   // Add refill, then take the ejected coin, then clamp at full scale.
   function automatic logic [CNT_W-1:0] inv_upd(input logic [CNT_W-1:0] cnt,
                                                input logic             add_en,
                                                input logic [CNT_W-1:0] add,
                                                input logic             dec);
      logic [CNT_W:0] s;
      s = {1'b0, cnt} + (add_en ? {1'b0, add} : {(CNT_W+1){1'b0}});
      if (dec && s != '0) s = s - 1'b1;
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // Feasibility: greedy 5-leu count bounded by stock, remainder in 1-leu coins.
   always_comb begin
      q5      = W'(amt_q) / W'(5);
      n5_calc = (q5 < W'(c5_q)) ? q5 : W'(c5_q);
      n1_calc = W'(amt_q) - n5_calc * W'(5);
      fits    = (n1_calc <= W'(c1_q));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      rr_nxt    = rr;
      amt_nxt   = amt_q;
      n5_nxt    = n5;
      n1_nxt    = n1;
      dec1      = 1'b0;
      dec5      = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_a || req_b) begin
               gnt_nxt   = (req_a && req_b) ? rr : req_b;
               amt_nxt   = gnt_nxt ? amt_b : amt_a;
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (fits) begin
               n5_nxt = AMT_W'(n5_calc);
               n1_nxt = AMT_W'(n1_calc);
            end
            if (amt_q == '0)  state_nxt = S_DONE;
            else if (!fits)   state_nxt = S_REJECT;
            else              state_nxt = S_EJECT;
         end
         S_EJECT: begin
            if (ej_done) begin
               if (n5 != '0) begin
                  n5_nxt = n5 - 1'b1;
                  dec5   = 1'b1;
               end else begin
                  n1_nxt = n1 - 1'b1;
                  dec1   = 1'b1;
               end
               state_nxt = S_GAP;
            end
         end
         S_GAP:    state_nxt = (n5 != '0 || n1 != '0) ? S_EJECT : S_DONE;
         S_DONE,
         S_REJECT: begin
            rr_nxt    = ~gnt;
            state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
      c1_nxt = inv_upd(c1_q, load_en, load_c1, dec1);
      c5_nxt = inv_upd(c5_q, load_en, load_c5, dec5);
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_comb begin
      ej5_d     = (state_nxt == S_EJECT) && (n5_nxt != '0);
      ej1_d     = (state_nxt == S_EJECT) && (n5_nxt == '0);
      ack_a_d   = (state_nxt == S_DONE)   && !gnt_nxt;
      ack_b_d   = (state_nxt == S_DONE)   &&  gnt_nxt;
      short_a_d = (state_nxt == S_REJECT) && !gnt_nxt;
      short_b_d = (state_nxt == S_REJECT) &&  gnt_nxt;
      busy_d    = (state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt     <= 1'b0;
         rr      <= 1'b0;
         amt_q   <= '0;
         n5      <= '0;
         n1      <= '0;
         c1_q    <= '0;
         c5_q    <= '0;
         ej1     <= 1'b0;
         ej5     <= 1'b0;
         ack_a   <= 1'b0;
         ack_b   <= 1'b0;
         short_a <= 1'b0;
         short_b <= 1'b0;
         busy    <= 1'b0;
      end else begin
         gnt     <= gnt_nxt;
         rr      <= rr_nxt;
         amt_q   <= amt_nxt;
         n5      <= n5_nxt;
         n1      <= n1_nxt;
         c1_q    <= c1_nxt;
         c5_q    <= c5_nxt;
         ej1     <= ej1_d;
         ej5     <= ej5_d;
         ack_a   <= ack_a_d;
         ack_b   <= ack_b_d;
         short_a <= short_a_d;
         short_b <= short_b_d;
         busy    <= busy_d;
      end
   end

   assign cnt1 = c1_q;
   assign cnt5 = c5_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: vector table of single payouts plus
// hand sequences for arbitration, ejector stall, saturation and mid-payout reset.
module tb_change_dispense_ctrl;
   localparam int AMT_W = 5;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_a, req_b, ej_done, load_en;
   logic [AMT_W-1:0] amt_a, amt_b;
   logic [CNT_W-1:0] load_c1, load_c5;
   logic             ack_a, short_a, ack_b, short_b, ej1, ej5, busy;
   logic [CNT_W-1:0] cnt1, cnt5;

   int tests = 0;
   int fails = 0;

   change_dispense_ctrl #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .amt_a(amt_a), .req_b(req_b), .amt_b(amt_b),
      .ack_a(ack_a), .short_a(short_a), .ack_b(ack_b), .short_b(short_b),
      .ej1(ej1), .ej5(ej5), .ej_done(ej_done),
      .load_en(load_en), .load_c1(load_c1), .load_c5(load_c5),
      .cnt1(cnt1), .cnt5(cnt5), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int c1, c5;          // preload
      int ch;              // 0=A, 1=B
      int amt;
      int exp_resp;        // {ack_a,short_a,ack_b,short_b}
      int exp_cyc;         // cycle of ack/short, request sampled at edge 0
      int exp_c1, exp_c5;  // inventory after
      int exp_n5, exp_n1;  // eject cycles seen (ej_done tied 1)
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; req_a = 0; req_b = 0; ej_done = 0; load_en = 0;
      amt_a = '0; amt_b = '0; load_c1 = '0; load_c5 = '0;
      #7;
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic load(input int c1, input int c5);
      @(negedge clk);
      load_en = 1'b1; load_c1 = CNT_W'(c1); load_c5 = CNT_W'(c5);
      @(negedge clk);
      load_en = 1'b0; load_c1 = '0; load_c5 = '0;
   endtask

   // Waits for any ack/short; drops the answered request in the same cycle.
   task automatic wait_resp(output int cyc, output int resp, output int n5c,
                            output int n1c, output int both);
      logic [3:0] r;
      cyc = -1; resp = 0; n5c = 0; n1c = 0; both = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (ej5) n5c++;
         if (ej1) n1c++;
         if (ej1 && ej5) both = 1;
         r = {ack_a, short_a, ack_b, short_b};
         if (r != 4'b0) begin
            cyc = c; resp = int'(r);
            if (r[3] || r[2]) req_a = 1'b0;
            if (r[1] || r[0]) req_b = 1'b0;
            return;
         end
      end
   endtask

   int cyc, resp, n5c, n1c, both, hi, lo1, ackc;
   bit seen;

   initial begin
      vt[0] = '{5, 2, 0,  7, 8,  8, 3, 1, 1, 2};
      vt[1] = '{2, 0, 1,  3, 1,  2, 2, 0, 0, 0};
      vt[2] = '{0, 0, 0,  0, 8,  2, 0, 0, 0, 0};
      vt[3] = '{3, 1, 1, 12, 1,  2, 3, 1, 0, 0};
      vt[4] = '{7, 1, 0, 12, 8, 18, 0, 0, 1, 7};
      vt[5] = '{0, 6, 1, 31, 1,  2, 0, 6, 0, 0};
      vt[6] = '{1, 6, 0, 31, 8, 16, 0, 0, 6, 1};
      vt[7] = '{10,0, 1, 10, 2, 22, 0, 0, 0,10};

      // reset state
      reset = 1'b0; req_a = 0; req_b = 0; ej_done = 1; load_en = 0;
      amt_a = '0; amt_b = '0; load_c1 = '0; load_c5 = '0;
      #3;
      chk("rst_outputs", int'({ack_a, short_a, ack_b, short_b, ej1, ej5, busy}), 0);
      chk("rst_cnt1", int'(cnt1), 0);
      chk("rst_cnt5", int'(cnt5), 0);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         load(vt[i].c1, vt[i].c5);
         ej_done = 1'b1;
         if (vt[i].ch == 0) begin req_a = 1'b1; amt_a = AMT_W'(vt[i].amt); end
         else               begin req_b = 1'b1; amt_b = AMT_W'(vt[i].amt); end
         wait_resp(cyc, resp, n5c, n1c, both);
         chk($sformatf("v%0d_resp", i), resp, vt[i].exp_resp);
         chk($sformatf("v%0d_cycle", i), cyc, vt[i].exp_cyc);
         chk($sformatf("v%0d_n_ej5", i), n5c, vt[i].exp_n5);
         chk($sformatf("v%0d_n_ej1", i), n1c, vt[i].exp_n1);
         chk($sformatf("v%0d_one_hot", i), both, 0);
         @(negedge clk);
         chk($sformatf("v%0d_cnt1", i), int'(cnt1), vt[i].exp_c1);
         chk($sformatf("v%0d_cnt5", i), int'(cnt5), vt[i].exp_c5);
         chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
      end

      // round-robin: A first after reset, then B, then A again
      do_reset();
      load(4, 0);
      ej_done = 1'b1; amt_a = 1; amt_b = 1; req_a = 1; req_b = 1;
      wait_resp(cyc, resp, n5c, n1c, both);
      chk("arb_p1_first", resp, 8);
      chk("arb_p1_cycle", cyc, 4);
      wait_resp(cyc, resp, n5c, n1c, both);
      chk("arb_p1_second", resp, 2);
      @(negedge clk);
      req_a = 1; req_b = 1;
      wait_resp(cyc, resp, n5c, n1c, both);
      chk("arb_p2_first", resp, 8);
      wait_resp(cyc, resp, n5c, n1c, both);
      chk("arb_p2_second", resp, 2);
      @(negedge clk);
      chk("arb_cnt1", int'(cnt1), 0);

      // ejector stall: ej_done low for 10 eject cycles
      do_reset();
      load(0, 1);
      ej_done = 1'b0; amt_a = 5; req_a = 1'b1;
      hi = 0; lo1 = 0; ackc = -1;
      for (int c = 1; c <= 40 && ackc < 0; c++) begin
         @(negedge clk);
         if (ej1) lo1++;
         if (ej5) begin
            hi++;
            if (hi == 5) chk("stall_cnt5_hold", int'(cnt5), 1);
            if (hi == 11) ej_done = 1'b1;
         end
         if (ack_a) begin ackc = c; req_a = 1'b0; end
      end
      chk("stall_ej5_cycles", hi, 11);
      chk("stall_ej1_cycles", lo1, 0);
      chk("stall_ack_cycle", ackc, 14);
      chk("stall_cnt5_after", int'(cnt5), 0);

      // saturation: refill and eject decrement on the same edge
      do_reset();
      load(200, 0);
      load(100, 0);
      chk("sat_refill_only", int'(cnt1), 255);
      ej_done = 1'b0; amt_a = 1; req_a = 1'b1; seen = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (ej1) seen = 1;
      end
      chk("sat_ej1_seen", int'(seen), 1);
      ej_done = 1'b1; load_en = 1'b1; load_c1 = 10; load_c5 = 3;
      @(negedge clk);
      ej_done = 1'b0; load_en = 1'b0; load_c1 = '0; load_c5 = '0;
      chk("sat_cnt1", int'(cnt1), 255);
      chk("sat_cnt5", int'(cnt5), 3);
      wait_resp(cyc, resp, n5c, n1c, both);
      chk("sat_ack", resp, 8);
      ej_done = 1'b1; amt_a = 1; req_a = 1'b1;
      wait_resp(cyc, resp, n5c, n1c, both);
      @(negedge clk);
      chk("sat_then_dec_cnt1", int'(cnt1), 254);

      // asynchronous reset mid-payout
      do_reset();
      load(3, 0);
      ej_done = 1'b0; amt_a = 2; req_a = 1'b1; seen = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (ej1) seen = 1;
      end
      chk("mid_ej1_seen", int'(seen), 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_ej1", int'(ej1), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_cnt1", int'(cnt1), 0);
      chk("mid_rst_cnt5", int'(cnt5), 0);
      req_a = 1'b0; ej_done = 1'b1;
      @(negedge clk);
      chk("mid_rst_no_ack", int'({ack_a, short_a}), 0);
      reset = 1'b1;
      load(2, 0);
      amt_b = 1; req_b = 1'b1;
      wait_resp(cyc, resp, n5c, n1c, both);
      chk("post_rst_resp", resp, 2);
      chk("post_rst_cycle", cyc, 4);
      @(negedge clk);
      chk("post_rst_cnt1", int'(cnt1), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
